// File: rtl/fifo_stream_unloader.sv
// fifo_stream_unloader: read-side stage behind a synchronous FIFO.
// Issues FIFO pops, captures the one-cycle-late read data into a small skid
// buffer and presents a valid/ready stream with packet framing (out_last).
// The pop request depends only on registered state and fifo_rempty, so
// out_ready has no combinational path to fifo_rinc.
module fifo_stream_unloader #(
    parameter int DSIZE = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] fifo_rdata,
    input  logic             fifo_rempty,
    output logic             fifo_rinc,
    input  logic [LEN_W-1:0] pkt_len,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    // Three entries cover the worst case: two words buffered plus one read
    // in flight while the consumer stalls, and still allow one beat per clock.
    logic [DSIZE-1:0] mem [0:2];
    logic [1:0]       head;
    logic [1:0]       tail;
    logic [1:0]       occ;
    logic             pend;
    logic [2:0]       fill;
    logic             pop;

    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] pkt_len_eff;
    logic [LEN_W-1:0] eff_len;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Buffered words plus the read in flight must never exceed capacity.
    assign fill      = {1'b0, occ} + {2'b00, pend};
    assign fifo_rinc = !rst && !fifo_rempty && (fill < 3'd3);

    assign pop       = out_valid && out_ready;
    assign out_valid = (occ != 2'd0);
    assign out_data  = mem[head];

    // A zero length is treated as single-beat packets; the live pkt_len is
    // used on the first beat, the latched length for the rest of the packet.
    assign pkt_len_eff = (pkt_len == '0) ? LEN_ONE : pkt_len;
    assign eff_len     = (beat_cnt == '0) ? pkt_len_eff : len_q;
    assign out_last    = out_valid && (beat_cnt == (eff_len - LEN_ONE));

    // Control state: pointers, occupancy, in-flight flag and packet framing.
    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= 2'd0;
            tail     <= 2'd0;
            occ      <= 2'd0;
            pend     <= 1'b0;
            beat_cnt <= '0;
            len_q    <= '0;
        end else begin
            pend <= fifo_rinc;
            if (pend) begin
                tail <= next_idx(tail);
            end
            if (pop) begin
                head <= next_idx(head);
            end
            occ <= occ + {1'b0, pend} - {1'b0, pop};
            if (out_valid && (beat_cnt == '0)) begin
                len_q <= pkt_len_eff;
            end
            if (pop) begin
                beat_cnt <= out_last ? '0 : beat_cnt + LEN_ONE;
            end
        end
    end

    // Storage: capture the word requested on the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
        end else if (pend) begin
            mem[tail] <= fifo_rdata;
        end
    end

endmodule

// File: tb/tb_fifo_stream_unloader.sv
// Bench for fifo_stream_unloader: a behavioural FIFO drives the DUT, and a
// queue-based reference (buffered words, in-flight flag, remaining beats in
// the packet) predicts every output each cycle.
module tb_fifo_stream_unloader;

    localparam int DSIZE = 32;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [DSIZE-1:0] fifo_rdata;
    logic             fifo_rempty;
    logic             fifo_rinc;
    logic [LEN_W-1:0] pkt_len;
    logic [DSIZE-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    fifo_stream_unloader #(.DSIZE(DSIZE), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .fifo_rinc   (fifo_rinc),
        .pkt_len     (pkt_len),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] len;
        int          n;
        logic [15:0] mask;
    } frame_vec_t;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // environment FIFO contents and reference model state
    logic [DSIZE-1:0] fifo_q[$];
    logic [DSIZE-1:0] buf_q[$];
    bit               pend_m = 1'b0;
    int               m_rem  = 0;

    // per-test logs
    int               beats;
    bit               last_log[$];
    logic [DSIZE-1:0] dat_log[$];
    logic [DSIZE-1:0] sent_q[$];
    int               first_rinc;
    int               first_valid;
    int               last_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_logs();
        beats       = 0;
        last_log.delete();
        dat_log.delete();
        sent_q.delete();
        first_rinc  = -1;
        first_valid = -1;
        last_valid  = -1;
    endtask

    // One clock: predict and compare outputs, then advance model and FIFO.
    task automatic step(input bit chk = 1'b1);
        bit   exp_rinc, exp_valid, exp_last, accept, rinc_now;
        int   len_now;
        fifo_rempty = (fifo_q.size() == 0);
        #1;
        exp_rinc  = !rst && (fifo_q.size() != 0) && ((buf_q.size() + int'(pend_m)) < 3);
        exp_valid = (buf_q.size() != 0);
        len_now   = (m_rem == 0) ? ((pkt_len == 0) ? 1 : int'(pkt_len)) : m_rem;
        exp_last  = exp_valid && (len_now == 1);
        if (chk) begin
            check("fifo_rinc", fifo_rinc, exp_rinc);
            check("rinc_while_empty", fifo_rinc && fifo_rempty, 0);
            check("out_valid", out_valid, exp_valid);
            if (exp_valid) begin
                check("out_data", out_data, buf_q[0]);
                check("out_last", out_last, exp_last);
            end else begin
                check("out_last_idle", out_last, 0);
            end
        end
        accept   = exp_valid && out_ready;
        rinc_now = fifo_rinc;
        if (rinc_now && first_rinc < 0) first_rinc = cyc;
        if (out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            last_valid = cyc;
        end
        if (accept) begin
            beats++;
            last_log.push_back(out_last);
            dat_log.push_back(out_data);
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            buf_q.delete();
            pend_m = 1'b0;
            m_rem  = 0;
        end else begin
            if (accept) begin
                void'(buf_q.pop_front());
                m_rem = len_now - 1;
            end
            if (pend_m) buf_q.push_back(fifo_rdata);
            pend_m = rinc_now;
        end
        #1;
        if (rinc_now && fifo_q.size() != 0) fifo_rdata = fifo_q.pop_front();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
        fifo_q.delete();
        clear_logs();
    endtask

    task automatic push_word(input logic [DSIZE-1:0] w);
        fifo_q.push_back(w);
        sent_q.push_back(w);
    endtask

    task automatic run_until_beats(input int target, input int budget, input string name);
        for (int k = 0; k < budget && beats < target; k++) step();
        check(name, beats, target);
    endtask

    frame_vec_t vecs[6];
    int         pat[4];

    initial begin
        vecs[0] = '{len: 16'd4, n: 12, mask: 16'h0888};
        vecs[1] = '{len: 16'd0, n: 5,  mask: 16'h001F};
        vecs[2] = '{len: 16'd1, n: 3,  mask: 16'h0007};
        vecs[3] = '{len: 16'd3, n: 6,  mask: 16'h0024};
        vecs[4] = '{len: 16'd2, n: 4,  mask: 16'h000A};
        vecs[5] = '{len: 16'd5, n: 7,  mask: 16'h0010};
        pat = '{1, 0, 0, 1};

        rst         = 1'b1;
        out_ready   = 1'b0;
        pkt_len     = 16'd4;
        fifo_rdata  = '0;
        fifo_rempty = 1'b1;
        clear_logs();
        step(1'b0);

        // Reset held with words waiting: no pop, no valid; then 2-cycle latency.
        for (int i = 0; i < 10; i++) push_word(32'h100 + i);
        rst = 1'b1;
        repeat (3) step();
        check("reset_out_data", out_data, 0);
        rst = 1'b0;
        clear_logs();
        for (int i = 0; i < 10; i++) sent_q.push_back(32'h100 + i);
        out_ready = 1'b1;
        repeat (16) step();
        check("reset_latency", first_valid - first_rinc, 2);
        check("reset_beats", beats, 10);

        // Full-rate stream of 0..99.
        do_reset(1);
        for (int i = 0; i < 100; i++) push_word(i);
        out_ready = 1'b1;
        repeat (110) step();
        check("stream_beats", beats, 100);
        check("stream_fill", first_valid - first_rinc, 2);
        check("stream_contiguous", last_valid - first_valid, 99);
        for (int i = 0; i < dat_log.size(); i++) check("stream_order", dat_log[i], i);

        // Table-driven framing vectors.
        for (int v = 0; v < 6; v++) begin
            do_reset(1);
            pkt_len = vecs[v].len;
            for (int i = 0; i < vecs[v].n; i++) push_word(32'h400 + i);
            out_ready = 1'b1;
            repeat (vecs[v].n + 6) step();
            check("frame_beats", beats, vecs[v].n);
            for (int i = 0; i < last_log.size() && i < 16; i++)
                check("frame_last", last_log[i], vecs[v].mask[i]);
        end

        // pkt_len changed mid-packet takes effect from the next packet.
        do_reset(1);
        pkt_len = 16'd4;
        for (int i = 0; i < 8; i++) push_word(32'h500 + i);
        out_ready = 1'b1;
        run_until_beats(2, 20, "midchg_wait");
        pkt_len = 16'd2;
        repeat (12) step();
        check("midchg_beats", beats, 8);
        for (int i = 0; i < last_log.size() && i < 8; i++)
            check("midchg_last", last_log[i], (i == 3 || i == 5 || i == 7) ? 1 : 0);

        // Backpressure 1,0,0,1 with random FIFO fill.
        do_reset(1);
        pkt_len = 16'd3;
        for (int k = 0; k < 400; k++) begin
            out_ready = pat[k % 4][0];
            if ($urandom_range(0, 1) == 1) push_word($urandom);
            step();
        end
        out_ready = 1'b1;
        repeat (30) step();
        check("bp_count", dat_log.size(), sent_q.size());
        for (int i = 0; i < dat_log.size() && i < sent_q.size(); i++)
            check("bp_order", dat_log[i], sent_q[i]);

        // Drain to empty: valid drops after the last word, no stale beat.
        do_reset(1);
        pkt_len = 16'd4;
        for (int i = 0; i < 3; i++) push_word(32'h700 + i);
        out_ready = 1'b1;
        repeat (12) step();
        check("empty_beats", beats, 3);
        #1;
        check("empty_valid_low", out_valid, 0);

        // Reset mid-packet: framing restarts from beat 0.
        do_reset(1);
        pkt_len = 16'd4;
        for (int i = 0; i < 10; i++) push_word(32'h600 + i);
        out_ready = 1'b1;
        run_until_beats(2, 20, "midrst_wait");
        out_ready = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_logs();
        out_ready = 1'b1;
        repeat (20) step();
        check("midrst_beats_ge4", beats >= 4, 1);
        for (int i = 0; i < last_log.size() && i < 5; i++)
            check("midrst_last", last_log[i], (i == 3) ? 1 : 0);
        check("midrst_valid_low", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
